slip_frame_decoder: RTL and testbench
=====================================

Name: slip_frame_decoder

Overview:
- Sits directly downstream of the UART receiver's RX FIFO and consumes its byte stream.
- Decodes SLIP (RFC 1055) framing into AXI-Stream packets: un-escapes bytes, strips END delimiters and marks the last byte of each frame with tlast.
- Flags malformed or oversize frames on tuser alongside tlast, so packet consumers can drop them.

Parameters:
- MAX_FRAME_LEN, 1024: maximum decoded payload bytes per frame; longer frames are truncated and flagged.
- DROP_EMPTY, 1: 1 means back-to-back END bytes produce no output; 0 is reserved and must not be used (elaboration error).

Ports:
- clk  input  1  system clock; sink and source share it.
- reset  input  1  asynchronous, active-high reset.
- sink.tdata  input  8  raw byte from the UART RX FIFO.
- sink.tvalid  input  1  raw byte valid.
- sink.tready  output  1  decoder accepts the raw byte.
- source.tdata  output  8  decoded payload byte.
- source.tvalid  output  1  decoded byte valid.
- source.tready  input  1  downstream accepts.
- source.tlast  output  1  last byte of the frame.
- source.tuser  output  1  frame error, meaningful only when tlast=1.

Behaviour:
- Constants: END=8'hC0, ESC=8'hDB, ESC_END=8'hDC, ESC_ESC=8'hDD.
- Reset values: source.tvalid=0, tdata=0, tlast=0, tuser=0; hold_valid=0; err=0; count=0; state=IDLE.
- Output path is a single output register. sink.tready = !source.tvalid || source.tready (combinational).
- A byte transfers when tvalid && tready on that interface. Output tvalid must not drop until the transfer completes, and tdata/tlast/tuser must stay stable while stalled.
- Hold register (hold_data, hold_valid) delays each decoded byte by one. The byte is emitted only when the next event is known, so it can carry the correct tlast.
- Minimum latency: a decoded byte reaches source one cycle after the sink byte that follows it is accepted.
- count, width $clog2(MAX_FRAME_LEN+1), tracks decoded bytes in the current frame, including the held byte.
- States:
  - IDLE: no hold.
    - END: consumed, stay (empty frame dropped).
    - ESC: go to ESCAPE.
    - Other byte: load hold, count=1, go to DATA.
  - DATA: hold valid.
    - Data byte (or un-escaped byte): if count==MAX_FRAME_LEN, emit hold with tlast=1, tuser=1, clear hold, go to DISCARD. Otherwise emit hold with tlast=0, load new byte, count++.
    - ESC: go to ESCAPE.
    - END: emit hold with tlast=1, tuser=err, clear err/count, go to IDLE.
  - ESCAPE:
    - ESC_END maps to C0 and ESC_ESC maps to DB, then treated as a data byte (same rules as DATA, including the first byte of a frame).
    - Any other byte except END: set err=1, treat the byte literally as data.
    - END: set err=1, then apply the END rule. If no hold exists, the frame is dropped silently.
  - DISCARD: consume bytes until END, then go to IDLE; nothing is emitted.
- Simultaneous events: if an output handshake completes in the same cycle a new byte is loaded into the output register, the new byte wins.
- Reset asserted mid-frame clears all state immediately. No partial tlast is generated.

Optional Feature:
- Macro: SLIP_FRAME_DECODER_STATS_EN.
- Defined: adds outputs frame_count[31:0] and error_count[31:0], both reset to 0.
  - frame_count increments on each emitted tlast transfer.
  - error_count increments on each emitted tlast transfer with tuser=1.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package slip_pkg holds:
  - SLIP_END, SLIP_ESC, SLIP_ESC_END and SLIP_ESC_ESC byte constants;
  - typedef enum logic [1:0] slip_dec_state_t {IDLE, DATA, ESCAPE, DISCARD}.
- The package is shared with the future slip_frame_encoder on the TX side.
- No sub-module. The output register is inline; it is not worth a generic skid buffer.

Test Plan:
- Input C0 01 02 03 C0 with source.tready=1 -> output 01,02,03; tlast only on 03; tuser=0.
- Input 41 DB DC 42 DB DD C0 -> output 41,C0,42,DB; tlast on DB; tuser=0.
- Input C0 C0 C0 05 C0 -> single output 05 with tlast=1; no output for the empty frames.
- Input 10 DB 7F 11 C0 -> output 10,7F,11; tlast on 11 with tuser=1. Next frame 22 C0 -> 22 with tuser=0 (err cleared).
- MAX_FRAME_LEN=4, input 01..06 C0 then 09 C0:
  - output 01..04 with tlast on 04, tuser=1;
  - 05, 06 discarded;
  - then 09 tlast, tuser=0.
- Random source.tready stalls (~50%) on a 20-byte escaped frame, plus reset asserted mid-frame:
  - stream matches the golden model with stable data under stall;
  - after reset, tvalid=0 and the next frame decodes cleanly.

Source files
------------

// File: rtl/slip_pkg.sv
// ----------------------------------------------------------------------------
// slip_pkg
// Shared SLIP (RFC 1055) definitions for the RX-side frame decoder and the
// TX-side frame encoder.
//   SLIP_END / SLIP_ESC / SLIP_ESC_END / SLIP_ESC_ESC : special byte values
//   slip_dec_state_t                                  : decoder FSM states
// ----------------------------------------------------------------------------
package slip_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        ESCAPE  = 2'd2,
        DISCARD = 2'd3
    } slip_dec_state_t;

endpackage

// File: rtl/slip_frame_decoder.sv
// ----------------------------------------------------------------------------
// slip_frame_decoder
// Converts the raw SLIP byte stream from the UART RX FIFO into AXI-Stream
// packets: escapes are undone, END delimiters are stripped, the last payload
// byte of each frame carries tlast, and tuser flags a bad frame (bad escape
// sequence or truncation at MAX_FRAME_LEN bytes) alongside tlast.
//
// Parameters
//   MAX_FRAME_LEN : max decoded payload bytes per frame (longer -> truncated,
//                   flagged, remainder discarded up to the next END)
//   DROP_EMPTY    : must be 1 (empty frames produce no output)
//
// Ports
//   clk           : clock shared by sink and source
//   reset         : asynchronous, active-high
//   sink_tdata    : raw byte in
//   sink_tvalid   : raw byte valid
//   sink_tready   : raw byte accepted
//   source_tdata  : decoded byte out
//   source_tvalid : decoded byte valid
//   source_tready : downstream accepts
//   source_tlast  : last byte of frame
//   source_tuser  : frame error, meaningful with tlast
//   frame_count   : (SLIP_FRAME_DECODER_STATS_EN) tlast transfers, wraps
//   error_count   : (SLIP_FRAME_DECODER_STATS_EN) tlast transfers with tuser
//
// Optional build macro: SLIP_FRAME_DECODER_STATS_EN adds the two counters.
// ----------------------------------------------------------------------------
module slip_frame_decoder
    import slip_pkg::*;
#(
    parameter int unsigned MAX_FRAME_LEN = 1024,
    parameter int unsigned DROP_EMPTY    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sink_tdata,
    input  logic        sink_tvalid,
    output logic        sink_tready,
    output logic [7:0]  source_tdata,
    output logic        source_tvalid,
    input  logic        source_tready,
    output logic        source_tlast,
    output logic        source_tuser
`ifdef SLIP_FRAME_DECODER_STATS_EN
    ,
    output logic [31:0] frame_count,
    output logic [31:0] error_count
`endif
);

    localparam int unsigned    CW      = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_FRAME_LEN);
    localparam logic [CW-1:0]  ONE     = CW'(1);

    generate
        if (DROP_EMPTY != 1) begin : g_bad_drop_empty
            $error("slip_frame_decoder: DROP_EMPTY=0 is reserved and unsupported");
        end
    endgenerate

    slip_dec_state_t state, n_state;
    logic [7:0]      hold_data, n_hold_data;
    logic            hold_valid, n_hold_valid;
    logic            err, n_err;
    logic [CW-1:0]   count, n_count;

    logic            accept;
    logic            data_ev;     // a (possibly un-escaped) payload byte arrived
    logic            end_ev;      // frame terminator arrived
    logic [7:0]      byte_val;    // payload value for data_ev
    logic            emit;        // load hold_data into the output register
    logic            emit_last;
    logic            emit_user;

    // The output register is the only buffer: any sink byte may cause at most
    // one emission, so accepting only when that register is free or draining
    // this cycle can never overrun it.
    assign sink_tready = !source_tvalid || source_tready;
    assign accept      = sink_tvalid && sink_tready;

    always_comb begin
        n_state      = state;
        n_hold_data  = hold_data;
        n_hold_valid = hold_valid;
        n_err        = err;
        n_count      = count;
        data_ev      = 1'b0;
        end_ev       = 1'b0;
        byte_val     = sink_tdata;
        emit         = 1'b0;
        emit_last    = 1'b0;
        emit_user    = 1'b0;

        // Classify the incoming byte first; the payload and END rules below are
        // shared by DATA and ESCAPE so that an un-escaped byte follows exactly
        // the same hold/count/truncation path as a plain one.
        if (accept) begin
            case (state)
                IDLE: begin
                    if (sink_tdata == SLIP_ESC) begin
                        n_state = ESCAPE;
                    end else if (sink_tdata != SLIP_END) begin
                        data_ev = 1'b1;
                    end
                end
                DATA: begin
                    if (sink_tdata == SLIP_ESC) begin
                        n_state = ESCAPE;
                    end else if (sink_tdata == SLIP_END) begin
                        end_ev = 1'b1;
                    end else begin
                        data_ev = 1'b1;
                    end
                end
                ESCAPE: begin
                    if (sink_tdata == SLIP_ESC_END) begin
                        data_ev  = 1'b1;
                        byte_val = SLIP_END;
                    end else if (sink_tdata == SLIP_ESC_ESC) begin
                        data_ev  = 1'b1;
                        byte_val = SLIP_ESC;
                    end else if (sink_tdata == SLIP_END) begin
                        n_err  = 1'b1;
                        end_ev = 1'b1;
                    end else begin
                        n_err   = 1'b1;
                        data_ev = 1'b1;
                    end
                end
                DISCARD: begin
                    if (sink_tdata == SLIP_END) begin
                        n_state = IDLE;
                    end
                end
                default: n_state = IDLE;
            endcase
        end

        if (data_ev) begin
            if (!hold_valid) begin
                n_hold_data  = byte_val;
                n_hold_valid = 1'b1;
                n_count      = ONE;
                n_state      = DATA;
            end else if (count == MAX_CNT) begin
                // Frame full: close it as errored and drop the rest.
                emit         = 1'b1;
                emit_last    = 1'b1;
                emit_user    = 1'b1;
                n_hold_valid = 1'b0;
                n_count      = '0;
                n_err        = 1'b0;
                n_state      = DISCARD;
            end else begin
                emit         = 1'b1;
                n_hold_data  = byte_val;
                n_count      = count + ONE;
                n_state      = DATA;
            end
        end

        if (end_ev) begin
            if (hold_valid) begin
                emit      = 1'b1;
                emit_last = 1'b1;
                emit_user = n_err;
            end
            n_hold_valid = 1'b0;
            n_err        = 1'b0;
            n_count      = '0;
            n_state      = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hold_data     <= '0;
            hold_valid    <= 1'b0;
            err           <= 1'b0;
            count         <= '0;
            source_tvalid <= 1'b0;
            source_tdata  <= '0;
            source_tlast  <= 1'b0;
            source_tuser  <= 1'b0;
        end else begin
            state      <= n_state;
            hold_data  <= n_hold_data;
            hold_valid <= n_hold_valid;
            err        <= n_err;
            count      <= n_count;
            // A new emission overrides the drain of the previous byte.
            if (emit) begin
                source_tvalid <= 1'b1;
                source_tdata  <= hold_data;
                source_tlast  <= emit_last;
                source_tuser  <= emit_user;
            end else if (source_tvalid && source_tready) begin
                source_tvalid <= 1'b0;
            end
        end
    end

`ifdef SLIP_FRAME_DECODER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
            error_count <= '0;
        end else if (source_tvalid && source_tready && source_tlast) begin
            frame_count <= frame_count + 32'd1;
            if (source_tuser) begin
                error_count <= error_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_slip_frame_decoder.sv
// ----------------------------------------------------------------------------
// tb_slip_frame_decoder
// Directed bench for slip_frame_decoder. dut0 uses the default frame length,
// dut1 uses MAX_FRAME_LEN=4; `sel` picks which one the driver and monitor use.
// Output words are recorded as {tlast, tuser, tdata}.
// ----------------------------------------------------------------------------
module tb_slip_frame_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       stall_en = 1'b0;
    logic       src_ready = 1'b1;
    logic [7:0] sink_tdata = 8'h00;
    logic       sink_tvalid = 1'b0;

    logic       tv0, tv1, tr0, tr1;
    logic [7:0] d0, d1;
    logic       v0, v1, l0, l1, u0, u1;
    logic       cur_tready, cur_valid, cur_last, cur_user;
    logic [7:0] cur_data;
    logic [9:0] cur_word;

    int checks = 0;
    int failures = 0;

    logic [9:0] out_q[$];
    logic       prev_stall = 1'b0;
    logic [9:0] prev_word = '0;

`ifdef SLIP_FRAME_DECODER_STATS_EN
    logic [31:0] fc0, ec0, fc1, ec1;
`endif

    assign tv0 = sink_tvalid && !sel;
    assign tv1 = sink_tvalid && sel;
    assign cur_tready = sel ? tr1 : tr0;
    assign cur_valid  = sel ? v1 : v0;
    assign cur_data   = sel ? d1 : d0;
    assign cur_last   = sel ? l1 : l0;
    assign cur_user   = sel ? u1 : u0;
    assign cur_word   = {cur_last, cur_user, cur_data};

    slip_frame_decoder dut0 (
        .clk(clk), .reset(rst),
        .sink_tdata(sink_tdata), .sink_tvalid(tv0), .sink_tready(tr0),
        .source_tdata(d0), .source_tvalid(v0), .source_tready(src_ready),
        .source_tlast(l0), .source_tuser(u0)
`ifdef SLIP_FRAME_DECODER_STATS_EN
        , .frame_count(fc0), .error_count(ec0)
`endif
    );

    slip_frame_decoder #(.MAX_FRAME_LEN(4), .DROP_EMPTY(1)) dut1 (
        .clk(clk), .reset(rst),
        .sink_tdata(sink_tdata), .sink_tvalid(tv1), .sink_tready(tr1),
        .source_tdata(d1), .source_tvalid(v1), .source_tready(src_ready),
        .source_tlast(l1), .source_tuser(u1)
`ifdef SLIP_FRAME_DECODER_STATS_EN
        , .frame_count(fc1), .error_count(ec1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        src_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Record transfers and check output stability across stalls.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (cur_valid !== 1'b1 || cur_word !== prev_word) begin
                    failures++;
                    $display("FAIL stall_hold got valid=%b word=%h exp valid=1 word=%h",
                             cur_valid, cur_word, prev_word);
                end
            end
            if (cur_valid && src_ready) out_q.push_back(cur_word);
            prev_stall = cur_valid && !src_ready;
            prev_word  = cur_word;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        logic done = 1'b0;
        sink_tdata  = b;
        sink_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (cur_tready) begin
                done = 1'b1;
            end else if (++n > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout got tready=0 exp tready=1 byte=%h", b);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        sink_tvalid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic drain(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({v0, l0, u0, d0} !== 11'h000) begin
            failures++;
            $display("FAIL reset_out0 got v=%b l=%b u=%b d=%h exp all 0", v0, l0, u0, d0);
        end
        checks++;
        if (v1 !== 1'b0 || tr0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_misc got v1=%b tready0=%b exp v1=0 tready0=1", v1, tr0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain(2);
    endtask

    task automatic test_basic();
        logic [7:0] seq[$];
        logic [9:0] exp[$];
        logic [9:0] g;
        out_q.delete();
        seq = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'hC0};
        exp = '{10'h001, 10'h002, 10'h203};
        send_seq(seq);
        drain(6);
        checks++;
        if (out_q.size() !== exp.size()) begin
            failures++;
            $display("FAIL basic_len got=%0d exp=%0d", out_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < out_q.size()) ? out_q[i] : 'x;
            checks++;
            if (g !== exp[i]) begin
                failures++;
                $display("FAIL basic[%0d] got=%h exp=%h", i, g, exp[i]);
            end
        end
    endtask

    task automatic test_escape();
        logic [7:0] seq[$];
        logic [9:0] exp[$];
        logic [9:0] g;
        out_q.delete();
        seq = '{8'h41, 8'hDB, 8'hDC, 8'h42, 8'hDB, 8'hDD, 8'hC0};
        exp = '{10'h041, 10'h0C0, 10'h042, 10'h2DB};
        send_seq(seq);
        drain(6);
        checks++;
        if (out_q.size() !== exp.size()) begin
            failures++;
            $display("FAIL escape_len got=%0d exp=%0d", out_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < out_q.size()) ? out_q[i] : 'x;
            checks++;
            if (g !== exp[i]) begin
                failures++;
                $display("FAIL escape[%0d] got=%h exp=%h", i, g, exp[i]);
            end
        end
    endtask

    task automatic test_empty_frames();
        logic [7:0] seq[$];
        logic [9:0] g;
        out_q.delete();
        seq = '{8'hC0, 8'hC0, 8'hC0, 8'h05, 8'hC0};
        send_seq(seq);
        drain(6);
        checks++;
        if (out_q.size() !== 1) begin
            failures++;
            $display("FAIL empty_len got=%0d exp=1", out_q.size());
        end
        g = (out_q.size() > 0) ? out_q[0] : 'x;
        checks++;
        if (g !== 10'h205) begin
            failures++;
            $display("FAIL empty_word got=%h exp=205", g);
        end
    endtask

    task automatic test_bad_escape();
        logic [7:0] seq[$];
        logic [9:0] exp[$];
        logic [9:0] g;
        out_q.delete();
        // bad escape; clean frame; ESC END ending a frame; lone ESC END; clean.
        seq = '{8'h10, 8'hDB, 8'h7F, 8'h11, 8'hC0,
                8'h22, 8'hC0,
                8'h33, 8'hDB, 8'hC0,
                8'hDB, 8'hC0,
                8'h44, 8'hC0};
        exp = '{10'h010, 10'h07F, 10'h311, 10'h222, 10'h333, 10'h244};
        send_seq(seq);
        drain(6);
        checks++;
        if (out_q.size() !== exp.size()) begin
            failures++;
            $display("FAIL badesc_len got=%0d exp=%0d", out_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < out_q.size()) ? out_q[i] : 'x;
            checks++;
            if (g !== exp[i]) begin
                failures++;
                $display("FAIL badesc[%0d] got=%h exp=%h", i, g, exp[i]);
            end
        end
    endtask

    task automatic test_truncate();
        logic [7:0] seq[$];
        logic [9:0] exp[$];
        logic [9:0] g;
        sel = 1'b1;
        out_q.delete();
        // exactly MAX (4) bytes is fine; 6 bytes truncates after 4.
        seq = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hC0,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hC0,
                8'h09, 8'hC0};
        exp = '{10'h00A, 10'h00B, 10'h00C, 10'h20D,
                10'h001, 10'h002, 10'h003, 10'h304, 10'h209};
        send_seq(seq);
        drain(6);
        sel = 1'b0;
        checks++;
        if (out_q.size() !== exp.size()) begin
            failures++;
            $display("FAIL trunc_len got=%0d exp=%0d", out_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < out_q.size()) ? out_q[i] : 'x;
            checks++;
            if (g !== exp[i]) begin
                failures++;
                $display("FAIL trunc[%0d] got=%h exp=%h", i, g, exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] pay[$];
        logic [7:0] seq[$];
        logic [9:0] exp[$];
        logic [9:0] g;
        out_q.delete();
        pay = '{8'h01, 8'hC0, 8'h02, 8'hDB, 8'h03, 8'h04, 8'hC0, 8'hC0, 8'h05, 8'h06,
                8'hDB, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'hC0, 8'h0D, 8'h0E};
        seq.push_back(8'hC0);
        foreach (pay[i]) begin
            if (pay[i] == 8'hC0) begin
                seq.push_back(8'hDB);
                seq.push_back(8'hDC);
            end else if (pay[i] == 8'hDB) begin
                seq.push_back(8'hDB);
                seq.push_back(8'hDD);
            end else begin
                seq.push_back(pay[i]);
            end
            exp.push_back({(i == pay.size() - 1), 1'b0, pay[i]});
        end
        seq.push_back(8'hC0);
        stall_en = 1'b1;
        send_seq(seq);
        stall_en = 1'b0;
        drain(8);
        checks++;
        if (out_q.size() !== exp.size()) begin
            failures++;
            $display("FAIL stall_len got=%0d exp=%0d", out_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < out_q.size()) ? out_q[i] : 'x;
            checks++;
            if (g !== exp[i]) begin
                failures++;
                $display("FAIL stall[%0d] got=%h exp=%h", i, g, exp[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] seq[$];
        logic [9:0] exp[$];
        logic [9:0] g;
        out_q.delete();
        seq = '{8'hC0, 8'h11, 8'h22, 8'h33};
        send_seq(seq);
        // 22 sits in the output register, 33 in hold: reset now.
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0 || l0 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_out got v=%b l=%b exp v=0 l=0", v0, l0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seq = '{8'h44, 8'h55, 8'hC0};
        exp = '{10'h011, 10'h044, 10'h255};
        send_seq(seq);
        drain(6);
        checks++;
        if (out_q.size() !== exp.size()) begin
            failures++;
            $display("FAIL midrst_len got=%0d exp=%0d", out_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < out_q.size()) ? out_q[i] : 'x;
            checks++;
            if (g !== exp[i]) begin
                failures++;
                $display("FAIL midrst[%0d] got=%h exp=%h", i, g, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_escape();
        test_empty_frames();
        test_bad_escape();
        test_truncate();
        test_stall();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
